// File: rtl/uart_core_cfg.sv
// Full-duplex UART with a TX FIFO and an RX FIFO between a strobe-driven host and the serial pins.
// Latency: tx falls two cycles after a write into an idle core; RX bytes reach the FIFO one cycle after the stop-bit centre sample.
// Backpressure: writes while tx_full are dropped; a received byte is dropped with an rx_overrun pulse when the RX FIFO is full.
//
// Ports: clk/rst (sync, active high); rx/tx serial pins (idle high); parity_odd selects odd parity;
//        tx_wr_en/tx_wr_data/tx_full/tx_busy host TX side; rx_rd_en/rx_rd_data/rx_empty host RX side (show-ahead);
//        rx_frame_err/rx_parity_err/rx_overrun one-cycle error pulses.
// Optional feature: define UART_PARITY_EN to add a parity bit after the data bits in both directions.

module uart_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_nxt;
    logic          do_wr, do_rd;

    // A full FIFO refuses writes even if it is popped in the same cycle.
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_comb begin
        count_nxt = count;
        if (do_wr && !do_rd) count_nxt = count + CNT_ONE;
        if (do_rd && !do_wr) count_nxt = count - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
            count <= count_nxt;
            full  <= (count_nxt == CNT_MAX);
            empty <= (count_nxt == '0);
        end
    end

    assign rd_data = empty ? '0 : mem[rd_ptr];
endmodule

module uart_core_cfg #(
    parameter int CLK_DIV    = 16,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic                 tx,
    input  logic                 parity_odd,
    input  logic                 tx_wr_en,
    input  logic [DATA_BITS-1:0] tx_wr_data,
    output logic                 tx_full,
    output logic                 tx_busy,
    input  logic                 rx_rd_en,
    output logic [DATA_BITS-1:0] rx_rd_data,
    output logic                 rx_empty,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_ONE   = 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    // ---------------- TX ----------------
    logic [2:0]           tx_state;
    logic [CW-1:0]        tx_cnt;
    logic [2:0]           tx_bit_idx;
    logic                 tx_stop_idx;
    logic [DATA_BITS-1:0] tx_shreg;
    logic [DATA_BITS-1:0] tx_head;
    logic                 tx_fifo_empty, tx_pop, tx_tick, tx_nxt;
`ifdef UART_PARITY_EN
    logic                 tx_par_bit;
`else
    logic                 unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    uart_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst),
        .wr_en(tx_wr_en), .wr_data(tx_wr_data),
        .rd_en(tx_pop), .rd_data(tx_head),
        .full(tx_full), .empty(tx_fifo_empty)
    );

    assign tx_tick = (tx_cnt == CNT_LAST);
    assign tx_busy = (tx_state != S_IDLE) || !tx_fifo_empty;

    // The head is popped on the same edge the FSM enters START, including the
    // stop-to-start hand-off that keeps back-to-back frames gap-free.
    always_comb begin
        tx_pop = 1'b0;
        if (tx_state == S_IDLE && !tx_fifo_empty)
            tx_pop = 1'b1;
        else if (tx_state == S_STOP && tx_tick && tx_stop_idx == STOP_LAST && !tx_fifo_empty)
            tx_pop = 1'b1;
    end

    always_comb begin
        tx_nxt = 1'b1;
        case (tx_state)
            S_START:  tx_nxt = 1'b0;
            S_DATA:   tx_nxt = tx_shreg[0];
`ifdef UART_PARITY_EN
            S_PARITY: tx_nxt = tx_par_bit;
`endif
            default:  tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx          <= 1'b1;
            tx_state    <= S_IDLE;
            tx_cnt      <= '0;
            tx_bit_idx  <= '0;
            tx_stop_idx <= 1'b0;
            tx_shreg    <= '0;
`ifdef UART_PARITY_EN
            tx_par_bit  <= 1'b0;
`endif
        end else begin
            // Pin is registered from the state, so it trails the FSM by one cycle.
            tx <= tx_nxt;
            if (tx_state != S_IDLE) tx_cnt <= tx_tick ? '0 : tx_cnt + CNT_ONE;
            if (tx_pop) begin
                tx_state <= S_START;
                tx_shreg <= tx_head;
`ifdef UART_PARITY_EN
                tx_par_bit <= (^tx_head) ^ parity_odd;
`endif
            end else if (tx_tick) begin
                case (tx_state)
                    S_START: begin
                        tx_state   <= S_DATA;
                        tx_bit_idx <= '0;
                    end
                    S_DATA: begin
                        if (tx_bit_idx == BIT_LAST) begin
`ifdef UART_PARITY_EN
                            tx_state <= S_PARITY;
`else
                            tx_state <= S_STOP;
`endif
                            tx_stop_idx <= 1'b0;
                        end else begin
                            tx_bit_idx <= tx_bit_idx + 3'd1;
                            tx_shreg   <= tx_shreg >> 1;
                        end
                    end
                    S_PARITY: begin
                        tx_state    <= S_STOP;
                        tx_stop_idx <= 1'b0;
                    end
                    S_STOP: begin
                        if (tx_stop_idx == STOP_LAST) tx_state <= S_IDLE;
                        else                          tx_stop_idx <= tx_stop_idx + 1'b1;
                    end
                    default: tx_state <= S_IDLE;
                endcase
            end
        end
    end

    // ---------------- RX ----------------
    logic                 rx_s1, rx_s2, rx_prev;
    logic [2:0]           rx_state;
    logic [CW-1:0]        rx_cnt;
    logic [2:0]           rx_bit_idx;
    logic [DATA_BITS-1:0] rx_shreg;
    logic                 rx_done_q, rx_stop_q, rx_good, rx_fifo_full;
`ifdef UART_PARITY_EN
    logic                 rx_par_odd_q, rx_par_ok, rx_par_ok_q;
    assign rx_good = rx_done_q && rx_stop_q && rx_par_ok_q;
`else
    assign rx_good = rx_done_q && rx_stop_q;
    assign rx_parity_err = 1'b0;
`endif

    // rx_shreg stays stable for half a bit after the stop sample, so it can feed the FIFO directly.
    uart_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst),
        .wr_en(rx_good), .wr_data(rx_shreg),
        .rd_en(rx_rd_en), .rd_data(rx_rd_data),
        .full(rx_fifo_full), .empty(rx_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1        <= 1'b1;
            rx_s2        <= 1'b1;
            rx_prev      <= 1'b1;
            rx_state     <= S_IDLE;
            rx_cnt       <= '0;
            rx_bit_idx   <= '0;
            rx_shreg     <= '0;
            rx_done_q    <= 1'b0;
            rx_stop_q    <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_odd_q  <= 1'b0;
            rx_par_ok     <= 1'b0;
            rx_par_ok_q   <= 1'b0;
            rx_parity_err <= 1'b0;
`endif
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            // Verdict pulses line up with the FIFO write, one cycle after the stop sample.
            rx_done_q    <= 1'b0;
            rx_frame_err <= rx_done_q && !rx_stop_q;
            rx_overrun   <= rx_good && rx_fifo_full;
`ifdef UART_PARITY_EN
            rx_parity_err <= rx_done_q && rx_stop_q && !rx_par_ok_q;
`endif
            case (rx_state)
                S_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rx_state <= S_START;
                        rx_cnt   <= '0;
`ifdef UART_PARITY_EN
                        rx_par_odd_q <= parity_odd;
`endif
                    end
                end
                S_START: begin
                    // Half-bit re-check rejects short low glitches.
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt     <= '0;
                        rx_bit_idx <= '0;
                        rx_state   <= rx_s2 ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (rx_cnt == CNT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shreg <= {rx_s2, rx_shreg[DATA_BITS-1:1]};
                        if (rx_bit_idx == BIT_LAST) begin
`ifdef UART_PARITY_EN
                            rx_state <= S_PARITY;
`else
                            rx_state <= S_STOP;
`endif
                        end else begin
                            rx_bit_idx <= rx_bit_idx + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (rx_cnt == CNT_LAST) begin
                        rx_cnt    <= '0;
                        rx_par_ok <= (rx_s2 == ((^rx_shreg) ^ rx_par_odd_q));
                        rx_state  <= S_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
`endif
                S_STOP: begin
                    // Only the first stop bit is checked; any further ones look like idle line.
                    if (rx_cnt == CNT_LAST) begin
                        rx_cnt    <= '0;
                        rx_done_q <= 1'b1;
                        rx_stop_q <= rx_s2;
`ifdef UART_PARITY_EN
                        rx_par_ok_q <= rx_par_ok;
`endif
                        rx_state  <= S_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_core_cfg.sv
module tb_uart_core_cfg;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, parity_odd = 1'b0;
    logic       tx_wr_en = 1'b0, rx_rd_en = 1'b0;
    logic [7:0] tx_wr_data = 8'h00;
    logic       loop = 1'b1, rx_force = 1'b1;
    logic       tx, tx_full, tx_busy, rx_empty, rx_frame_err, rx_parity_err, rx_overrun, rx_in;
    logic [7:0] rx_rd_data;
    assign rx_in = loop ? tx : rx_force;

    uart_core_cfg u_dut (
        .clk(clk), .rst(rst), .rx(rx_in), .tx(tx), .parity_odd(parity_odd),
        .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data), .tx_full(tx_full), .tx_busy(tx_busy),
        .rx_rd_en(rx_rd_en), .rx_rd_data(rx_rd_data), .rx_empty(rx_empty),
        .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err), .rx_overrun(rx_overrun)
    );

    logic       s_wr_en = 1'b0, s_rd_en = 1'b0;
    logic [7:0] s_wr_data = 8'h00;
    logic       s_tx, s_tx_full, s_tx_busy, s_rx_empty, s_fe, s_pe, s_ov;
    logic [7:0] s_rd_data;

    uart_core_cfg #(.FIFO_DEPTH(4)) u_small (
        .clk(clk), .rst(rst), .rx(s_tx), .tx(s_tx), .parity_odd(parity_odd),
        .tx_wr_en(s_wr_en), .tx_wr_data(s_wr_data), .tx_full(s_tx_full), .tx_busy(s_tx_busy),
        .rx_rd_en(s_rd_en), .rx_rd_data(s_rd_data), .rx_empty(s_rx_empty),
        .rx_frame_err(s_fe), .rx_parity_err(s_pe), .rx_overrun(s_ov)
    );

    int passed = 0, total = 0;
    int cyc = 0, arrive_cyc = 0;
    int fe_cnt = 0, pe_cnt = 0, ov_cnt = 0;
    logic prev_empty = 1'b1;

    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (rx_frame_err === 1'b1)  fe_cnt++;
        if (rx_parity_err === 1'b1) pe_cnt++;
        if (rx_overrun === 1'b1)    ov_cnt++;
        if (prev_empty && rx_empty === 1'b0) arrive_cyc = cyc;
        prev_empty = rx_empty;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_rx(input int limit);
        int n = 0;
        while (rx_empty && n < limit) begin tick(1); n++; end
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (tx_busy && n < limit) begin tick(1); n++; end
    endtask

    task automatic pop();
        rx_rd_en = 1'b1; tick(1); rx_rd_en = 1'b0;
    endtask

    // Drives one frame on rx with the given stop level and optional parity corruption.
    task automatic send_raw(input logic [7:0] d, input logic stop, input logic flip);
        rx_force = 1'b0; tick(16);
        for (int i = 0; i < 8; i++) begin rx_force = d[i]; tick(16); end
`ifdef UART_PARITY_EN
        rx_force = (^d) ^ parity_odd ^ flip; tick(16);
`else
        if (flip) tick(0);
`endif
        rx_force = stop; tick(16);
        rx_force = 1'b1; tick(16);
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(3);
        total++; if (tx !== 1'b1)         $display("FAIL reset_tx: got %b want 1", tx); else passed++;
        total++; if (tx_full !== 1'b0)    $display("FAIL reset_tx_full: got %b want 0", tx_full); else passed++;
        total++; if (tx_busy !== 1'b0)    $display("FAIL reset_tx_busy: got %b want 0", tx_busy); else passed++;
        total++; if (rx_empty !== 1'b1)   $display("FAIL reset_rx_empty: got %b want 1", rx_empty); else passed++;
        total++; if (rx_rd_data !== 8'h00) $display("FAIL reset_rd_data: got %h want 00", rx_rd_data); else passed++;
        total++; if ({rx_frame_err, rx_parity_err, rx_overrun} !== 3'b000)
            $display("FAIL reset_err_pulses: got %b want 000", {rx_frame_err, rx_parity_err, rx_overrun}); else passed++;
        rst = 1'b0; tick(2);
    endtask

    task automatic test_single_frame();
        int t0;
        tx_wr_data = 8'h55; tx_wr_en = 1'b1; tick(1); tx_wr_en = 1'b0;
        t0 = cyc;
        total++; if (tx_busy !== 1'b1) $display("FAIL sf_busy_n: got %b want 1", tx_busy); else passed++;
        tick(1);
        total++; if (tx !== 1'b1) $display("FAIL sf_tx_n1: got %b want 1", tx); else passed++;
        tick(1);
        total++; if (tx !== 1'b0) $display("FAIL sf_tx_fall_n2: got %b want 0", tx); else passed++;
        tick(15);
        total++; if (tx !== 1'b0) $display("FAIL sf_start_end: got %b want 0", tx); else passed++;
        tick(1);
        total++; if (tx !== 1'b1) $display("FAIL sf_bit0: got %b want 1", tx); else passed++;
        tick(142);
        total++; if (tx_busy !== 1'b1) $display("FAIL sf_busy_n160: got %b want 1", tx_busy); else passed++;
        tick(1);
        total++; if (tx_busy !== 1'b0) $display("FAIL sf_busy_n161: got %b want 0", tx_busy); else passed++;
        wait_rx(100);
        total++; if (rx_empty !== 1'b0 || (arrive_cyc - t0) < 150 || (arrive_cyc - t0) > 170)
            $display("FAIL sf_rx_latency: got %0d cycles want 150..170", arrive_cyc - t0); else passed++;
        total++; if (rx_rd_data !== 8'h55) $display("FAIL sf_rx_data: got %h want 55", rx_rd_data); else passed++;
        pop();
        total++; if (rx_empty !== 1'b1 || rx_rd_data !== 8'h00)
            $display("FAIL sf_after_pop: got empty=%b data=%h want 1/00", rx_empty, rx_rd_data); else passed++;
    endtask

    task automatic test_back_to_back();
        tx_wr_data = 8'h55; tx_wr_en = 1'b1; tick(1);
        tx_wr_data = 8'hA3; tick(1); tx_wr_en = 1'b0;
        tick(160);
        total++; if (tx !== 1'b1) $display("FAIL b2b_stop: got %b want 1", tx); else passed++;
        tick(1);
        total++; if (tx !== 1'b0) $display("FAIL b2b_no_gap: got %b want 0", tx); else passed++;
        wait_rx(400);
        total++; if (rx_rd_data !== 8'h55) $display("FAIL b2b_first: got %h want 55", rx_rd_data); else passed++;
        pop(); wait_rx(400);
        total++; if (rx_rd_data !== 8'hA3) $display("FAIL b2b_second: got %h want a3", rx_rd_data); else passed++;
        pop();
        total++; if (rx_empty !== 1'b1) $display("FAIL b2b_empty: got %b want 1", rx_empty); else passed++;
        wait_idle(400);
    endtask

    task automatic test_read_empty();
        pop();
        total++; if (rx_empty !== 1'b1 || rx_rd_data !== 8'h00)
            $display("FAIL rd_empty: got empty=%b data=%h want 1/00", rx_empty, rx_rd_data); else passed++;
    endtask

    task automatic test_full_boundary();
        logic [7:0] exp_q [5];
        exp_q = '{8'h10, 8'h20, 8'h21, 8'h22, 8'h23};
        s_wr_data = 8'h10; s_wr_en = 1'b1; tick(1); s_wr_en = 1'b0; tick(3);
        for (int i = 0; i < 5; i++) begin
            s_wr_data = 8'h20 + 8'(i); s_wr_en = 1'b1; tick(1);
            if (i == 2) begin
                total++; if (s_tx_full !== 1'b0) $display("FAIL full_after3: got %b want 0", s_tx_full); else passed++;
            end
            if (i == 3) begin
                total++; if (s_tx_full !== 1'b1) $display("FAIL full_after4: got %b want 1", s_tx_full); else passed++;
            end
        end
        s_wr_en = 1'b0;
        for (int j = 0; j < 5; j++) begin
            int n = 0;
            while (s_rx_empty && n < 400) begin tick(1); n++; end
            total++; if (s_rx_empty !== 1'b0 || s_rd_data !== exp_q[j])
                $display("FAIL full_rx%0d: got empty=%b data=%h want 0/%h", j, s_rx_empty, s_rd_data, exp_q[j]); else passed++;
            s_rd_en = 1'b1; tick(1); s_rd_en = 1'b0;
        end
        tick(400);
        total++; if (s_rx_empty !== 1'b1 || s_tx_busy !== 1'b0)
            $display("FAIL full_fifth_dropped: got empty=%b busy=%b want 1/0", s_rx_empty, s_tx_busy); else passed++;
    endtask

    task automatic test_frame_error();
        int fe0 = fe_cnt;
        loop = 1'b0; rx_force = 1'b1; tick(5);
        send_raw(8'h3C, 1'b0, 1'b0); tick(5);
        total++; if (fe_cnt !== fe0 + 1) $display("FAIL ferr_pulse: got %0d want %0d", fe_cnt, fe0 + 1); else passed++;
        total++; if (rx_empty !== 1'b1) $display("FAIL ferr_no_write: got %b want 1", rx_empty); else passed++;
        rx_force = 1'b0; tick(3); rx_force = 1'b1; tick(40);
        total++; if (fe_cnt !== fe0 + 1 || rx_empty !== 1'b1)
            $display("FAIL glitch_ignored: got fe=%0d empty=%b want %0d/1", fe_cnt, rx_empty, fe0 + 1); else passed++;
        send_raw(8'hC3, 1'b1, 1'b0);
        total++; if (rx_empty !== 1'b0 || rx_rd_data !== 8'hC3)
            $display("FAIL raw_good: got empty=%b data=%h want 0/c3", rx_empty, rx_rd_data); else passed++;
        pop();
        loop = 1'b1; tick(5);
    endtask

    task automatic test_overrun();
        int ov0 = ov_cnt;
        tx_wr_data = 8'h40; tx_wr_en = 1'b1; tick(1); tx_wr_en = 1'b0; tick(20);
        for (int i = 1; i <= 16; i++) begin
            tx_wr_data = 8'h40 + 8'(i); tx_wr_en = 1'b1; tick(1);
        end
        tx_wr_en = 1'b0;
        total++; if (tx_full !== 1'b1) $display("FAIL ovr_tx_full: got %b want 1", tx_full); else passed++;
        wait_idle(3200); tick(10);
        total++; if (ov_cnt !== ov0 + 1) $display("FAIL ovr_pulse: got %0d want %0d", ov_cnt, ov0 + 1); else passed++;
        for (int i = 0; i < 16; i++) begin
            total++; if (rx_empty !== 1'b0 || rx_rd_data !== 8'h40 + 8'(i))
                $display("FAIL ovr_rx%0d: got empty=%b data=%h want 0/%h", i, rx_empty, rx_rd_data, 8'h40 + 8'(i)); else passed++;
            pop();
        end
        total++; if (rx_empty !== 1'b1) $display("FAIL ovr_17th_dropped: got %b want 1", rx_empty); else passed++;
    endtask

    task automatic test_reset_mid();
        tx_wr_data = 8'h11; tx_wr_en = 1'b1; tick(1); tx_wr_en = 1'b0;
        wait_rx(400);
        tx_wr_data = 8'h22; tx_wr_en = 1'b1; tick(1); tx_wr_en = 1'b0;
        tick(50);
        rst = 1'b1; tick(1);
        total++; if (tx !== 1'b1 || tx_busy !== 1'b0)
            $display("FAIL rstmid_tx: got tx=%b busy=%b want 1/0", tx, tx_busy); else passed++;
        total++; if (rx_empty !== 1'b1 || rx_rd_data !== 8'h00)
            $display("FAIL rstmid_rx: got empty=%b data=%h want 1/00", rx_empty, rx_rd_data); else passed++;
        rst = 1'b0; tick(200);
        total++; if (rx_empty !== 1'b1) $display("FAIL rstmid_no_rx: got %b want 1", rx_empty); else passed++;
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity();
        int pe0 = pe_cnt;
        parity_odd = 1'b1;
        tx_wr_data = 8'hA3; tx_wr_en = 1'b1; tick(1); tx_wr_en = 1'b0;
        wait_rx(400);
        total++; if (rx_rd_data !== 8'hA3 || pe_cnt !== pe0)
            $display("FAIL par_ok: got data=%h pe=%0d want a3/%0d", rx_rd_data, pe_cnt, pe0); else passed++;
        pop(); wait_idle(400);
        loop = 1'b0; rx_force = 1'b1; tick(5);
        send_raw(8'hA3, 1'b1, 1'b1); tick(5);
        total++; if (pe_cnt !== pe0 + 1 || rx_empty !== 1'b1)
            $display("FAIL par_err: got pe=%0d empty=%b want %0d/1", pe_cnt, rx_empty, pe0 + 1); else passed++;
        loop = 1'b1; tick(5);
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_read_empty();
        test_full_boundary();
        test_frame_error();
        test_overrun();
`ifdef UART_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
